// File: rtl/uart_bus_responder_pkg.sv
// Shared constants and types for the UART bus responder.
// No logic of its own; address offsets, CON bit positions and TX FSM states.
// Imported by the responder top and its byte FIFO.
package uart_bus_responder_pkg;

   localparam int BYTE_W = 8;

   // Register offsets from BASE_ADDR
   localparam logic [31:0] TXD_OFS = 32'h0000_0000;
   localparam logic [31:0] RXD_OFS = 32'h0000_0004;
   localparam logic [31:0] CON_OFS = 32'h0000_0008;

   // CON register bit positions
   localparam int CON_RX_IE   = 0;
   localparam int CON_TX_IE   = 1;
   localparam int CON_RX_NE   = 2;
   localparam int CON_TX_FULL = 3;
   localparam int CON_TX_BUSY = 4;
   localparam int CON_RX_OVR  = 5;
   localparam int CON_TX_OVF  = 6;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      LAUNCH     = 2'd1,
      WAIT_START = 2'd2,
      WAIT_DONE  = 2'd3
   } tx_state_t;

endpackage

// File: rtl/uart_bus_responder_byte_fifo.sv
// Byte FIFO, DEPTH entries, pointers carry an extra wrap bit.
// dout shows the head combinationally; push/pop take effect on the clock edge.
// Push while full is dropped unless a pop frees the slot on the same edge; pop while empty is ignored.
module byte_fifo
   import uart_bus_responder_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic [BYTE_W-1:0] din,
   output logic [BYTE_W-1:0] dout,
   output logic              full,
   output logic              empty
);

   localparam int AW = $clog2(DEPTH);

   logic [BYTE_W-1:0] mem [DEPTH];
   logic [AW:0]       wr_ptr;
   logic [AW:0]       rd_ptr;
   logic              do_pop;
   logic              do_push;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr[AW-1:0]];

   // Pointer advance on accepted push/pop
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage write; contents need no reset because the pointers gate visibility
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/uart_bus_responder.sv
// Bus responder bridging CPU loads/stores to uart_tx/uart_rx through TX and RX byte FIFOs.
// TXD write to idle empty FIFO -> TX_EN two edges later; RX byte visible in CON/irq the next cycle.
// No bus stall: writes to a full TX FIFO and RX bytes into a full RX FIFO are dropped and flagged sticky.
module uart_bus_responder
   import uart_bus_responder_pkg::*;
#(
   parameter int          DEPTH     = 4,
   parameter logic [31:0] BASE_ADDR = 32'h4000_0018
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rd,
   input  logic        wr,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   input  logic        RX_STATUS,
   input  logic [7:0]  RX_DATA,
   input  logic        TX_STATUS,
   output logic        TX_EN,
   output logic [7:0]  TX_DATA,
   output logic        irq
);

   tx_state_t   state_q, state_d;
   logic        txd_hit, rxd_hit, con_hit, con_wr;
   logic        tx_push, tx_pop, tx_full, tx_empty, load_data;
   logic        rx_pop, rx_full, rx_empty;
   logic [7:0]  tx_head, rx_head;
   logic        rx_ie, tx_ie, rx_ovr, tx_ovf;
   logic        rx_ovr_set, tx_ovf_set, tx_busy;
   logic [31:0] con_val;
   logic        unused_wdata;

   assign txd_hit = (addr == BASE_ADDR + TXD_OFS);
   assign rxd_hit = (addr == BASE_ADDR + RXD_OFS);
   assign con_hit = (addr == BASE_ADDR + CON_OFS);
   assign con_wr  = wr & con_hit;
   assign tx_push = wr & txd_hit;
   assign rx_pop  = rd & rxd_hit & ~rx_empty;

   assign tx_ovf_set = tx_push & tx_full & ~tx_pop;
   assign rx_ovr_set = RX_STATUS & rx_full & ~rx_pop;
   assign tx_busy    = ~tx_empty | (state_q != IDLE);
   assign irq        = (rx_ie & ~rx_empty) | (tx_ie & ~tx_busy);
   assign TX_EN      = (state_q == LAUNCH);
   assign unused_wdata = ^wdata[31:8];

   byte_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (tx_push),
      .pop   (tx_pop),
      .din   (wdata[7:0]),
      .dout  (tx_head),
      .full  (tx_full),
      .empty (tx_empty)
   );

   byte_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (RX_STATUS),
      .pop   (rx_pop),
      .din   (RX_DATA),
      .dout  (rx_head),
      .full  (rx_full),
      .empty (rx_empty)
   );

   // CON read image assembled from live state and sticky flags
   always_comb begin
      con_val              = '0;
      con_val[CON_RX_IE]   = rx_ie;
      con_val[CON_TX_IE]   = tx_ie;
      con_val[CON_RX_NE]   = ~rx_empty;
      con_val[CON_TX_FULL] = tx_full;
      con_val[CON_TX_BUSY] = tx_busy;
      con_val[CON_RX_OVR]  = rx_ovr;
      con_val[CON_TX_OVF]  = tx_ovf;
   end

   // Read mux: zero unless a matched read; empty RXD reads also return zero
   always_comb begin
      rdata = '0;
      if (rd) begin
         if (rxd_hit && !rx_empty) rdata = {24'b0, rx_head};
         else if (con_hit)         rdata = con_val;
      end
   end

   // Interrupt enables and sticky overrun flags; a new event wins over a clear
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_ie  <= 1'b0;
         tx_ie  <= 1'b0;
         rx_ovr <= 1'b0;
         tx_ovf <= 1'b0;
      end else begin
         if (con_wr) begin
            rx_ie <= wdata[CON_RX_IE];
            tx_ie <= wdata[CON_TX_IE];
         end
         if (rx_ovr_set)                         rx_ovr <= 1'b1;
         else if (con_wr && wdata[CON_RX_OVR])   rx_ovr <= 1'b0;
         if (tx_ovf_set)                         tx_ovf <= 1'b1;
         else if (con_wr && wdata[CON_TX_OVF])   tx_ovf <= 1'b0;
      end
   end

   // TX launch FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // TX launch FSM next state; head is captured entering LAUNCH so TX_DATA is valid with TX_EN
   always_comb begin
      state_d   = state_q;
      tx_pop    = 1'b0;
      load_data = 1'b0;
      case (state_q)
         IDLE: begin
            if (!tx_empty && !TX_STATUS) begin
               state_d   = LAUNCH;
               load_data = 1'b1;
            end
         end
         LAUNCH: begin
            tx_pop  = 1'b1;
            state_d = WAIT_START;
         end
         WAIT_START: if (TX_STATUS)  state_d = WAIT_DONE;
         WAIT_DONE:  if (!TX_STATUS) state_d = IDLE;
         default:    state_d = IDLE;
      endcase
   end

   // TX byte holding register, stable until the next launch
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)         TX_DATA <= 8'h00;
      else if (load_data) TX_DATA <= tx_head;
   end

endmodule

// File: tb/tb_uart_bus_responder.sv
module tb_uart_bus_responder;

   localparam int          DEPTH = 4;
   localparam logic [31:0] TXD   = 32'h4000_0018;
   localparam logic [31:0] RXD   = 32'h4000_001C;
   localparam logic [31:0] CON   = 32'h4000_0020;

   logic        clk, reset, rd, wr;
   logic [31:0] addr, wdata, rdata;
   logic        RX_STATUS, TX_STATUS, TX_EN, irq;
   logic [7:0]  RX_DATA, TX_DATA;

   int total = 0;
   int bad   = 0;

   // uart_tx model state
   logic [7:0] sent_q[$];
   logic [7:0] last_sent;
   int         busy_left = 0;
   int         busy_len  = 20;
   bit         tx_hold   = 0;
   bit         chk_stable = 1;

   uart_bus_responder #(.DEPTH(DEPTH), .BASE_ADDR(TXD)) dut (
      .clk       (clk),
      .reset     (reset),
      .rd        (rd),
      .wr        (wr),
      .addr      (addr),
      .wdata     (wdata),
      .rdata     (rdata),
      .RX_STATUS (RX_STATUS),
      .RX_DATA   (RX_DATA),
      .TX_STATUS (TX_STATUS),
      .TX_EN     (TX_EN),
      .TX_DATA   (TX_DATA),
      .irq       (irq)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   // uart_tx behaviour: busy for busy_len cycles after each TX_EN, or held busy by tx_hold
   initial begin
      TX_STATUS = 0;
      forever begin
         @(negedge clk);
         if (TX_EN === 1'b1) begin
            total++;
            if (TX_STATUS !== 1'b0) begin
               bad++;
               $display("FAIL tx_en_while_busy: TX_STATUS=%b required 0", TX_STATUS);
            end
            sent_q.push_back(TX_DATA);
            last_sent = TX_DATA;
            busy_left = busy_len;
         end else if (busy_left > 0) begin
            if (chk_stable) begin
               total++;
               if (TX_DATA !== last_sent) begin
                  bad++;
                  $display("FAIL tx_data_stable: got %h required %h", TX_DATA, last_sent);
               end
            end
            busy_left--;
         end
         TX_STATUS = tx_hold || (busy_left > 0);
      end
   end

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      wr = 1; addr = a; wdata = d;
      @(posedge clk); #1;
      wr = 0; addr = '0; wdata = '0;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      @(negedge clk);
      rd = 1; addr = a;
      #1 d = rdata;
      @(posedge clk); #1;
      rd = 0; addr = '0;
   endtask

   task automatic rx_push(input logic [7:0] b);
      @(negedge clk);
      RX_STATUS = 1; RX_DATA = b;
      @(posedge clk); #1;
      RX_STATUS = 0;
   endtask

   task automatic wait_sent(input int n);
      int cyc = 0;
      while (sent_q.size() < n && cyc < 3000) begin
         @(negedge clk);
         cyc++;
      end
      total++;
      if (sent_q.size() < n) begin
         bad++;
         $display("FAIL wait_sent: got %0d bytes required %0d", sent_q.size(), n);
      end
   endtask

   task automatic wait_tx_idle();
      int cyc = 0;
      while ((TX_STATUS || busy_left > 0) && cyc < 3000) begin
         @(negedge clk);
         cyc++;
      end
      repeat (3) @(negedge clk);
      total++;
      if (TX_STATUS !== 1'b0) begin
         bad++;
         $display("FAIL wait_tx_idle: TX_STATUS=%b required 0", TX_STATUS);
      end
   endtask

   task automatic test_reset();
      logic [31:0] d;
      reset = 0; rd = 0; wr = 0; addr = '0; wdata = '0; RX_STATUS = 0; RX_DATA = '0;
      repeat (3) @(negedge clk);
      #1;
      total++; if (TX_EN !== 1'b0)   begin bad++; $display("FAIL reset_tx_en: got %b required 0", TX_EN); end
      total++; if (TX_DATA !== 8'h0) begin bad++; $display("FAIL reset_tx_data: got %h required 00", TX_DATA); end
      total++; if (irq !== 1'b0)     begin bad++; $display("FAIL reset_irq: got %b required 0", irq); end
      @(negedge clk) reset = 1;
      bus_read(CON, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_con: got %h required 0", d); end
      bus_read(TXD, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL txd_read: got %h required 0", d); end
      bus_read(CON + 32'd4, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL unmapped_read: got %h required 0", d); end
      @(negedge clk); addr = CON; #1;
      total++; if (rdata !== 32'h0) begin bad++; $display("FAIL rd_low_rdata: got %h required 0", rdata); end
      addr = '0;
      repeat (10) @(negedge clk);
      total++; if (sent_q.size() != 0) begin bad++; $display("FAIL reset_no_launch: got %0d launches required 0", sent_q.size()); end
   endtask

   task automatic test_tx_latency();
      logic [7:0] b = 8'($urandom);
      busy_len = $urandom_range(5, 12);
      bus_write(TXD, {24'b0, b});
      @(negedge clk); #1;
      total++; if (TX_EN !== 1'b0) begin bad++; $display("FAIL latency_early: TX_EN=%b required 0", TX_EN); end
      @(negedge clk); #1;
      total++; if (TX_EN !== 1'b1) begin bad++; $display("FAIL latency_pulse: TX_EN=%b required 1", TX_EN); end
      total++; if (TX_DATA !== b)  begin bad++; $display("FAIL latency_data: got %h required %h", TX_DATA, b); end
      wait_sent(1);
      wait_tx_idle();
      sent_q.delete();
   endtask

   task automatic test_back_to_back();
      logic [7:0] b[3];
      logic [31:0] d;
      busy_len = $urandom_range(8, 24);
      b[0] = 8'h41; b[1] = 8'h42; b[2] = 8'h43;
      if ($urandom_range(0, 1) == 1) for (int i = 0; i < 3; i++) b[i] = 8'($urandom);
      for (int i = 0; i < 3; i++) bus_write(TXD, {24'b0, b[i]});
      bus_read(CON, d);
      total++; if (d[4] !== 1'b1) begin bad++; $display("FAIL b2b_busy: CON=%h required bit4 set", d); end
      wait_sent(3);
      for (int i = 0; i < 3 && i < sent_q.size(); i++) begin
         total++;
         if (sent_q[i] !== b[i]) begin bad++; $display("FAIL b2b_order[%0d]: got %h required %h", i, sent_q[i], b[i]); end
      end
      wait_tx_idle();
      bus_read(CON, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL b2b_con_idle: got %h required 0", d); end
      sent_q.delete();
   endtask

   task automatic test_tx_overflow();
      logic [7:0] b[5];
      logic [31:0] d;
      busy_len = $urandom_range(4, 10);
      tx_hold = 1;
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         b[i] = 8'($urandom);
         bus_write(TXD, {24'b0, b[i]});
      end
      bus_read(CON, d);
      total++; if (d !== 32'h58) begin bad++; $display("FAIL ovf_con: got %h required 58", d); end
      bus_write(CON, 32'h40);
      bus_read(CON, d);
      total++; if (d !== 32'h18) begin bad++; $display("FAIL ovf_clear: got %h required 18", d); end
      tx_hold = 0;
      wait_sent(4);
      for (int i = 0; i < 4 && i < sent_q.size(); i++) begin
         total++;
         if (sent_q[i] !== b[i]) begin bad++; $display("FAIL ovf_order[%0d]: got %h required %h", i, sent_q[i], b[i]); end
      end
      wait_tx_idle();
      total++; if (sent_q.size() != 4) begin bad++; $display("FAIL ovf_count: got %0d required 4", sent_q.size()); end
      bus_read(CON, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL ovf_idle_con: got %h required 0", d); end
      sent_q.delete();
   endtask

   task automatic test_rx_basic();
      logic [31:0] d;
      rx_push(8'h55);
      rx_push(8'hAA);
      bus_read(RXD, d);
      total++; if (d !== 32'h55) begin bad++; $display("FAIL rx_first: got %h required 55", d); end
      bus_read(RXD, d);
      total++; if (d !== 32'hAA) begin bad++; $display("FAIL rx_second: got %h required AA", d); end
      bus_read(RXD, d);
      total++; if (d !== 32'h0)  begin bad++; $display("FAIL rx_empty_read: got %h required 0", d); end
      bus_read(CON, d);
      total++; if (d !== 32'h0)  begin bad++; $display("FAIL rx_empty_con: got %h required 0", d); end
   endtask

   task automatic test_irq();
      logic [31:0] d;
      logic [7:0]  b = 8'($urandom);
      bus_write(CON, 32'h1);
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_rx_idle: got %b required 0", irq); end
      rx_push(b);
      total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_rx_set: got %b required 1", irq); end
      bus_read(RXD, d);
      total++; if (d !== {24'b0, b}) begin bad++; $display("FAIL irq_rx_data: got %h required %h", d, b); end
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_rx_clear: got %b required 0", irq); end
      bus_write(CON, 32'h2);
      total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_tx_idle: got %b required 1", irq); end
      bus_write(CON, 32'h0);
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_off: got %b required 0", irq); end
   endtask

   task automatic test_rx_full_simul();
      logic [7:0]  b[6];
      logic [31:0] d;
      for (int i = 0; i < 6; i++) b[i] = 8'($urandom);
      for (int i = 0; i < 4; i++) rx_push(b[i]);
      @(negedge clk);
      RX_STATUS = 1; RX_DATA = b[4]; rd = 1; addr = RXD;
      #1 d = rdata;
      @(posedge clk); #1;
      RX_STATUS = 0; rd = 0; addr = '0;
      total++; if (d !== {24'b0, b[0]}) begin bad++; $display("FAIL full_simul_data: got %h required %h", d, b[0]); end
      bus_read(CON, d);
      total++; if (d !== 32'h04) begin bad++; $display("FAIL full_simul_con: got %h required 04", d); end
      rx_push(b[5]);
      bus_read(CON, d);
      total++; if (d !== 32'h24) begin bad++; $display("FAIL rx_ovr_set: got %h required 24", d); end
      // clear racing a fresh overrun keeps the flag
      @(negedge clk);
      wr = 1; addr = CON; wdata = 32'h20; RX_STATUS = 1; RX_DATA = 8'($urandom);
      @(posedge clk); #1;
      wr = 0; addr = '0; wdata = '0; RX_STATUS = 0;
      bus_read(CON, d);
      total++; if (d !== 32'h24) begin bad++; $display("FAIL ovr_clear_race: got %h required 24", d); end
      bus_write(CON, 32'h20);
      bus_read(CON, d);
      total++; if (d !== 32'h04) begin bad++; $display("FAIL ovr_clear: got %h required 04", d); end
      for (int i = 1; i <= 4; i++) begin
         bus_read(RXD, d);
         total++; if (d !== {24'b0, b[i]}) begin bad++; $display("FAIL full_drain[%0d]: got %h required %h", i, d, b[i]); end
      end
      bus_read(RXD, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL full_drain_empty: got %h required 0", d); end
   endtask

   task automatic test_rx_random();
      logic [7:0]  q[$];
      logic [7:0]  b;
      logic [31:0] d, exp;
      bit          p, r, ovr;
      ovr = 0;
      for (int i = 0; i < 120; i++) begin
         p = ($urandom_range(0, 9) < 5);
         r = ($urandom_range(0, 9) < 4);
         b = 8'($urandom);
         @(negedge clk);
         RX_STATUS = p; RX_DATA = b; rd = r; addr = RXD;
         #1;
         if (r) begin
            exp = (q.size() > 0) ? {24'b0, q[0]} : 32'h0;
            total++;
            if (rdata !== exp) begin bad++; $display("FAIL rx_rand[%0d]: got %h required %h", i, rdata, exp); end
         end
         @(posedge clk); #1;
         RX_STATUS = 0; rd = 0; addr = '0;
         if (r && q.size() > 0) void'(q.pop_front());
         if (p) begin
            if (q.size() < DEPTH) q.push_back(b);
            else ovr = 1;
         end
      end
      bus_read(CON, d);
      exp = {26'b0, ovr, 2'b0, (q.size() > 0), 2'b0};
      total++; if (d !== exp) begin bad++; $display("FAIL rx_rand_con: got %h required %h", d, exp); end
      while (q.size() > 0) begin
         bus_read(RXD, d);
         exp = {24'b0, q.pop_front()};
         total++; if (d !== exp) begin bad++; $display("FAIL rx_rand_drain: got %h required %h", d, exp); end
      end
      bus_write(CON, 32'h20);
   endtask

   task automatic test_reset_midframe();
      logic [7:0] a = 8'($urandom);
      logic [7:0] c = 8'($urandom);
      int cyc = 0;
      busy_len = 15;
      chk_stable = 0;
      bus_write(TXD, {24'b0, a});
      while (sent_q.size() < 1 && cyc < 50) begin @(negedge clk); cyc++; end
      #2 reset = 0;
      #1;
      total++; if (TX_EN !== 1'b0)   begin bad++; $display("FAIL midframe_tx_en: got %b required 0", TX_EN); end
      total++; if (TX_DATA !== 8'h0) begin bad++; $display("FAIL midframe_tx_data: got %h required 00", TX_DATA); end
      @(negedge clk) reset = 1;
      bus_write(TXD, {24'b0, c});
      wait_sent(2);
      total++; if (sent_q.size() > 0 && sent_q[0] !== a) begin bad++; $display("FAIL midframe_first: got %h required %h", sent_q[0], a); end
      total++; if (sent_q.size() > 1 && sent_q[1] !== c) begin bad++; $display("FAIL midframe_second: got %h required %h", sent_q[1], c); end
      wait_tx_idle();
      chk_stable = 1;
      sent_q.delete();
   endtask

   initial begin
      test_reset();
      test_tx_latency();
      test_back_to_back();
      test_tx_overflow();
      test_rx_basic();
      test_irq();
      test_rx_full_simul();
      test_rx_random();
      test_reset_midframe();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_bus_responder.md
Name: uart_bus_responder

Overview:
- Memory-mapped responder on the CPU data bus (rd/wr/addr/wdata/rdata, driven from the EX/MEM stage), sitting beside the Peripheral block.
- Bridges the bus to the uart_tx / uart_rx byte interfaces.
- Provides a TX FIFO with a launch state machine, an RX FIFO, status/control registers and an interrupt output.
- Lets software issue back-to-back UART writes without polling TX_STATUS.

Parameters:
- DEPTH, 4, entries per FIFO (power of 2, >=2).
- BASE_ADDR, 32'h40000018, address of TXD. RXD = BASE+4, CON = BASE+8.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- rd  in  1  bus read strobe, one cycle per access
- wr  in  1  bus write strobe, one cycle per access
- addr  in  32  bus byte address
- wdata  in  32  bus write data
- rdata  out  32  read data, combinational from registered state
- RX_STATUS  in  1  one-cycle byte-valid pulse from uart_rx
- RX_DATA  in  8  received byte, valid with RX_STATUS
- TX_STATUS  in  1  uart_tx active flag
- TX_EN  out  1  one-cycle launch pulse to uart_tx
- TX_DATA  out  8  byte to send, held stable from TX_EN until TX_STATUS falls
- irq  out  1  level interrupt

Behaviour:
- Reset (async, reset=0):
  - FIFOs empty, pointers 0.
  - FSM in IDLE; TX_EN=0, TX_DATA=0, irq=0.
  - CON enables and sticky flags = 0.
- Address decode: exact 32-bit match. Other addresses are ignored; rdata=0 when rd=0 or the address is unmatched.
- TXD write (wr, addr==TXD): push wdata[7:0] on the next edge if not full. If full, drop the byte and set tx_ovf sticky.
- TXD read: returns 0.
- RXD read (rd, addr==RXD):
  - rdata = {24'b0, head}; the pop happens on that edge.
  - If empty: rdata=0, no pop, no pointer change.
- RX push: RX_STATUS=1 pushes RX_DATA. If full and no simultaneous pop: drop the byte and set rx_ovr sticky. Full with a simultaneous pop: both succeed, no overrun.
- Simultaneous push and pop on a non-empty, non-full FIFO: count is unchanged and ordering is preserved.
- CON read bits:
  - [0] rx_ie, [1] tx_ie
  - [2] rx_nonempty, [3] tx_full
  - [4] tx_busy (TX FIFO non-empty OR FSM!=IDLE)
  - [5] rx_ovr, [6] tx_ovf
  - others 0
- CON write:
  - [1:0] load rx_ie/tx_ie.
  - Writing 1 to [5] clears rx_ovr; writing 1 to [6] clears tx_ovf.
  - A clear concurrent with a new overrun event leaves the flag set.
- irq = (rx_ie & rx_nonempty) | (tx_ie & ~tx_busy). Combinational from registered state.
- TX FSM:
  - IDLE: TX FIFO non-empty AND TX_STATUS=0 -> LAUNCH.
  - LAUNCH (1 cycle): TX_EN=1, TX_DATA<=head, pop -> WAIT_START.
  - WAIT_START: TX_STATUS=1 -> WAIT_DONE.
  - WAIT_DONE: TX_STATUS=0 -> IDLE.
  - A bus push during LAUNCH to a full FIFO succeeds, because the pop frees a slot the same edge.
  - Minimum gap between TX_EN pulses = full uart_tx frame + 2 cycles.
- Latency:
  - Write to TXD on an empty FIFO while idle -> TX_EN 2 cycles later (push edge, IDLE->LAUNCH edge).
  - RX_STATUS -> rx_nonempty/irq visible the next cycle.
- Pointers are log2(DEPTH)+1 bits with an extra wrap bit. full = MSBs differ and low bits equal.
- Reset mid-frame: FSM returns to IDLE and TX_EN drops immediately. uart_tx finishes its frame independently. After release, the FSM waits for TX_STATUS=0 before the next launch.

Decomposition:
- Shared package:
  - address offsets TXD/RXD/CON
  - CON bit index constants
  - FSM state enum {IDLE, LAUNCH, WAIT_START, WAIT_DONE}
- One sub-module: byte_fifo (parameter DEPTH; push/pop/din/dout/full/empty). Instantiate it twice, for TX and RX.

Test Plan:
- Reset, then read CON -> rdata=0x10? No: expect 0x00 (FIFOs empty, idle). irq=0. TX_EN never asserts.
- Write TXD 0x41, 0x42, 0x43 on consecutive cycles; model uart_tx busy 20 cycles. Expect three TX_EN pulses with TX_DATA 0x41, 0x42, 0x43 in order. Each pulse is issued only after TX_STATUS falls.
- Write 5 bytes with DEPTH=4 while TX_STATUS is held high. Expect the 5th byte dropped, CON[6]=1 and CON[3]=1. Write CON 0x40 -> CON[6]=0.
- Pulse RX_STATUS with 0x55, then 0xAA. Read RXD twice -> 0x55, then 0xAA. A third read -> 0, no pointer change, CON[2]=0.
- Set CON=0x1 and push 1 RX byte -> irq=1 the next cycle; read RXD -> irq=0. Set CON=0x2 while TX is idle -> irq=1.
- Fill RX with 4 bytes, then apply RX_STATUS and an RXD read on the same cycle. Expect no rx_ovr and count stays 4. A 6th push without a pop sets rx_ovr.
